// File: rtl/wic_bridge_pkg.sv
// Shared state encoding and error codes for the host-side frame transmit sequencer.
package wic_bridge_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_ENC_START = 4'd1,
        ST_ENC_WAIT  = 4'd2,
        ST_TX_LOAD   = 4'd3,
        ST_TX_START  = 4'd4,
        ST_TX_WAIT   = 4'd5,
        ST_TX_GAP    = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_FRAME   = 2'b01;
    localparam logic [1:0] ERR_ENC     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/host_frame_tx_sequencer.sv
// Host-side sequencer: latches a frame, runs the encoder handshake, streams the encoded bytes to uart_tx.
// Optional build macro FRAME_CHECKSUM_EN appends an XOR checksum byte after the encoded bytes.
module host_frame_tx_sequencer
    import wic_bridge_pkg::*;
#(
    parameter int IN_BYTES    = 128,
    parameter int OUT_BYTES   = 18,
    parameter int SIZE_W      = 8,
    parameter int ENC_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_valid,
    input  logic [IN_BYTES*8-1:0]  frame_data,
    input  logic [SIZE_W-1:0]      frame_size,
    input  logic                   frame_error,
    output logic                   frame_ready,
    output logic [IN_BYTES*8-1:0]  enc_data,
    output logic                   enc_start,
    input  logic [OUT_BYTES*8-1:0] enc_output,
    input  logic                   enc_done,
    input  logic                   enc_error,
    output logic [7:0]             tx_data,
    output logic                   tx_load,
    output logic                   tx_start,
    input  logic                   tx_finish,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code
);

    localparam int IDX_W = $clog2(OUT_BYTES + 1);
    localparam int TMR_W = $clog2(ENC_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ENC_TIMEOUT - 1);
`ifdef FRAME_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);
`endif

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [IN_BYTES*8-1:0]  enc_data_q, enc_data_d;
    logic [OUT_BYTES*8-1:0] enc_out_q, enc_out_d;
    logic [1:0]             code_q, code_d;
    logic                   enc_start_q;
    logic                   fin_sync;
    logic                   fin_prev_q;
    logic                   fin_rise;

    function automatic logic [7:0] pick_byte(input logic [OUT_BYTES*8-1:0] v,
                                             input logic [IDX_W-1:0]       i);
        pick_byte = 8'h00;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (i == IDX_W'(k)) pick_byte = v[8*k +: 8];
        end
    endfunction

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [OUT_BYTES*8-1:0] v);
        xor_bytes = 8'h00;
        for (int k = 0; k < OUT_BYTES; k++) begin
            xor_bytes = xor_bytes ^ v[8*k +: 8];
        end
    endfunction
`endif

    sync_2ff u_fin_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (tx_finish),
        .q_o   (fin_sync)
    );

    // Only a low-to-high transition counts; a level already high on entry is ignored.
    assign fin_rise = fin_sync & ~fin_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tmr_q       <= '0;
            enc_data_q  <= '0;
            enc_out_q   <= '0;
            code_q      <= ERR_NONE;
            enc_start_q <= 1'b0;
            fin_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            enc_data_q  <= enc_data_d;
            enc_out_q   <= enc_out_d;
            code_q      <= code_d;
            enc_start_q <= (state_q == ST_ENC_START);
            fin_prev_q  <= fin_sync;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_d      = tmr_q;
        enc_data_d = enc_data_q;
        enc_out_d  = enc_out_q;
        code_d     = code_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    if (frame_error || (frame_size == '0)) begin
                        code_d  = ERR_FRAME;
                        state_d = ST_ERR;
                    end else begin
                        enc_data_d = frame_data;
                        state_d    = ST_ENC_START;
                    end
                end
            end
            ST_ENC_START: begin
                tmr_d   = '0;
                state_d = ST_ENC_WAIT;
            end
            ST_ENC_WAIT: begin
                // The enc_start pulse is registered, so it coincides with timer value 0 here.
                if (enc_error) begin
                    code_d  = ERR_ENC;
                    state_d = ST_ERR;
                end else if (enc_done) begin
                    enc_out_d = enc_output;
                    idx_d     = '0;
                    state_d   = ST_TX_LOAD;
                end else if (tmr_q == TMR_LAST) begin
                    code_d  = ERR_TIMEOUT;
                    state_d = ST_ERR;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_TX_LOAD:  state_d = ST_TX_START;
            ST_TX_START: state_d = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (fin_rise) state_d = ST_TX_GAP;
            end
            ST_TX_GAP: begin
                if (!fin_sync) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_TX_LOAD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // tx_data only changes when idx or the latched command change, i.e. outside TX_LOAD..TX_GAP.
    always_comb begin
        tx_data = pick_byte(enc_out_q, idx_q);
`ifdef FRAME_CHECKSUM_EN
        if (idx_q == IDX_W'(OUT_BYTES)) tx_data = xor_bytes(enc_out_q);
`endif
    end

    assign frame_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign enc_data    = enc_data_q;
    assign enc_start   = enc_start_q;
    assign tx_load     = (state_q == ST_TX_LOAD);
    assign tx_start    = (state_q == ST_TX_START) || (state_q == ST_TX_WAIT);
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERR);
    assign error_code  = code_q;

endmodule

// File: tb/tb_host_frame_tx_sequencer.sv
// Scoreboard bench for host_frame_tx_sequencer with an encoder driven inline and a simple uart_tx model.
module tb_host_frame_tx_sequencer;

    localparam int IN_BYTES    = 128;
    localparam int OUT_BYTES   = 18;
    localparam int SIZE_W      = 8;
    localparam int ENC_TIMEOUT = 64;
`ifdef FRAME_CHECKSUM_EN
    localparam int N_TX = OUT_BYTES + 1;
`else
    localparam int N_TX = OUT_BYTES;
`endif

    logic                   clk;
    logic                   reset;
    logic                   frame_valid;
    logic [IN_BYTES*8-1:0]  frame_data;
    logic [SIZE_W-1:0]      frame_size;
    logic                   frame_error;
    logic                   frame_ready;
    logic [IN_BYTES*8-1:0]  enc_data;
    logic                   enc_start;
    logic [OUT_BYTES*8-1:0] enc_output;
    logic                   enc_done;
    logic                   enc_error;
    logic [7:0]             tx_data;
    logic                   tx_load;
    logic                   tx_start;
    logic                   tx_finish;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [1:0]             error_code;

    host_frame_tx_sequencer #(
        .IN_BYTES    (IN_BYTES),
        .OUT_BYTES   (OUT_BYTES),
        .SIZE_W      (SIZE_W),
        .ENC_TIMEOUT (ENC_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_size  (frame_size),
        .frame_error (frame_error),
        .frame_ready (frame_ready),
        .enc_data    (enc_data),
        .enc_start   (enc_start),
        .enc_output  (enc_output),
        .enc_done    (enc_done),
        .enc_error   (enc_error),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_start    (tx_start),
        .tx_finish   (tx_finish),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_code  (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    int         load_cnt = 0, load_mark = 0, first_load_cyc = 0;
    int         start_cnt = 0, start_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0, err_cyc = 0;
    int         fv_cyc = 0, ed_cyc = 0;
    logic       rdy_at_err = 1'b0, rdy_after_err = 1'b0, prev_err = 1'b0;
    logic [1:0] code_at_err = 2'b00;
    logic [7:0] last_tx = 8'h00;
    int         ucnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every tx_load and records event timing.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (tx_load) begin
                    if (load_cnt == load_mark) first_load_cyc = cyc;
                    if (exp_q.size() == 0) chk("tx_unexpected_load", 32'(exp_q.size()), 32'd1);
                    else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                    last_tx = tx_data;
                    load_cnt++;
                end
                if (enc_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                end
                if (done) done_cnt++;
                if (prev_err) rdy_after_err = frame_ready;
                if (error) begin
                    err_cnt++;
                    err_cyc     = cyc;
                    rdy_at_err  = frame_ready;
                    code_at_err = error_code;
                end
                prev_err = error;
            end
        end
    end

    // uart_tx model: raises finish a few cycles into tx_start, drops it once tx_start falls.
    initial begin
        tx_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                tx_finish = 1'b0;
                ucnt      = 0;
            end else if (tx_start && !tx_finish) begin
                ucnt++;
                if (ucnt == 4) tx_finish = 1'b1;
            end else if (!tx_start) begin
                ucnt      = 0;
                tx_finish = 1'b0;
            end
        end
    end

    function automatic logic [OUT_BYTES*8-1:0] pat(input int base, input int step);
        logic [OUT_BYTES*8-1:0] r;
        for (int k = 0; k < OUT_BYTES; k++) r[8*k +: 8] = 8'(base + k * step);
        return r;
    endfunction

    task automatic push_expected(input logic [OUT_BYTES*8-1:0] v);
        logic [7:0] cs;
        cs = 8'h00;
        for (int k = 0; k < OUT_BYTES; k++) begin
            exp_q.push_back(v[8*k +: 8]);
            cs = cs ^ v[8*k +: 8];
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic send_frame(input int size, input logic ferr, input int seed);
        @(negedge clk);
        for (int k = 0; k < IN_BYTES; k++) frame_data[8*k +: 8] = 8'(seed + k);
        frame_size  = SIZE_W'(size);
        frame_error = ferr;
        frame_valid = 1'b1;
        fv_cyc      = cyc;
        @(negedge clk);
        frame_valid = 1'b0;
        frame_error = 1'b0;
    endtask

    task automatic enc_reply(input logic [OUT_BYTES*8-1:0] v, input logic d, input logic e);
        enc_output = v;
        enc_done   = d;
        enc_error  = e;
        ed_cyc     = cyc;
        @(negedge clk);
        enc_done  = 1'b0;
        enc_error = 1'b0;
    endtask

    task automatic wait_start(input int target);
        for (int i = 0; i < 50 && start_cnt < target; i++) @(negedge clk);
        chk("enc_start_seen", 32'(start_cnt), 32'(target));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
        chk("done_seen", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_err(input int target, input int budget);
        for (int i = 0; i < budget && err_cnt < target; i++) @(negedge clk);
        chk("error_seen", 32'(err_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_frame_ready"}, {31'h0, frame_ready}, 32'd1);
        chk({tag, "_busy"},        {31'h0, busy},        32'd0);
        chk({tag, "_enc_start"},   {31'h0, enc_start},   32'd0);
        chk({tag, "_tx_load"},     {31'h0, tx_load},     32'd0);
        chk({tag, "_tx_start"},    {31'h0, tx_start},    32'd0);
        chk({tag, "_done"},        {31'h0, done},        32'd0);
        chk({tag, "_error"},       {31'h0, error},       32'd0);
        chk({tag, "_error_code"},  {30'h0, error_code},  32'd0);
        chk({tag, "_tx_data"},     {24'h0, tx_data},     32'd0);
        chk({tag, "_enc_data"},    {31'h0, |enc_data},   32'd0);
    endtask

    initial begin
        logic [OUT_BYTES*8-1:0] v;
        int s0, e0, l0, d0;

        reset       = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        frame_size  = '0;
        frame_error = 1'b0;
        enc_output  = '0;
        enc_done    = 1'b0;
        enc_error   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Normal frame, plus a frame_valid while busy that must be ignored.
        v = pat(8'h00, 1);
        push_expected(v);
        load_mark = load_cnt;
        send_frame(5, 1'b0, 8'h30);
        wait_start(1);
        chk("t1_start_latency", 32'(start_cyc - fv_cyc), 32'd2);
        chk("t1_enc_data_lo", enc_data[31:0], 32'h3332_3130);
        chk("t1_enc_data_hi", {24'h0, enc_data[8*127 +: 8]}, 32'h0000_00AF);
        send_frame(3, 1'b0, 8'h90);
        repeat (7) @(negedge clk);
        enc_reply(v, 1'b1, 1'b0);
        wait_done(1);
        chk("t1_load_latency", 32'(first_load_cyc - ed_cyc), 32'd1);
        chk("t1_start_once", 32'(start_cnt), 32'd1);
        chk("t1_bytes_sent", 32'(load_cnt - load_mark), 32'(N_TX));
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_busy_frame_ignored", {24'h0, enc_data[7:0]}, 32'h0000_0030);

        // Frame error, then zero size: no encoder start, two code-01 errors.
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(5, 1'b1, 8'h00);
        wait_err(e0 + 1, 20);
        chk("t2_code_ferr", {30'h0, code_at_err}, 32'd1);
        send_frame(0, 1'b0, 8'h55);
        wait_err(e0 + 2, 20);
        chk("t2_code_size0", {30'h0, code_at_err}, 32'd1);
        chk("t2_no_enc_start", 32'(start_cnt), 32'(s0));
        repeat (4) @(negedge clk);
        chk("t2_code_holds", {30'h0, error_code}, 32'd1);

        // Encoder silent: timeout.
        e0 = err_cnt;
        rdy_after_err = 1'b0;
        send_frame(4, 1'b0, 8'h11);
        wait_start(s0 + 1);
        wait_err(e0 + 1, 200);
        chk("t3_timeout_cycle", 32'(err_cyc - start_cyc), 32'(ENC_TIMEOUT));
        chk("t3_code", {30'h0, code_at_err}, 32'd3);
        chk("t3_not_ready_in_err", {31'h0, rdy_at_err}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_ready_after_err", {31'h0, rdy_after_err}, 32'd1);

        // enc_error and enc_done together: error wins, nothing transmitted.
        e0 = err_cnt;
        l0 = load_cnt;
        send_frame(6, 1'b0, 8'h22);
        wait_start(s0 + 2);
        repeat (3) @(negedge clk);
        enc_reply(pat(8'h80, 1), 1'b1, 1'b1);
        wait_err(e0 + 1, 20);
        chk("t4_code", {30'h0, code_at_err}, 32'd2);
        repeat (30) @(negedge clk);
        chk("t4_no_tx_load", 32'(load_cnt), 32'(l0));
        chk("t4_code_holds", {30'h0, error_code}, 32'd2);

        // Reset during byte 7 TX_WAIT, then a clean frame.
        v = pat(8'h40, 1);
        push_expected(v);
        send_frame(9, 1'b0, 8'h60);
        wait_start(s0 + 3);
        repeat (4) @(negedge clk);
        l0 = load_cnt;
        enc_reply(v, 1'b1, 1'b0);
        for (int i = 0; i < 500 && !(load_cnt >= l0 + 8 && tx_start); i++) @(negedge clk);
        chk("t5_reached_byte7", 32'(load_cnt - l0), 32'd8);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        #2 reset = 1'b0;
        #1 check_reset_outputs("t5_async");
        chk("t5_bytes_pending", 32'(exp_q.size()), 32'(N_TX - 8));
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done_pulse", 32'(done_cnt), 32'(d0));
        chk("t5_no_err_pulse", 32'(err_cnt), 32'(e0));
        v = pat(8'h07, 7);
        push_expected(v);
        s0 = start_cnt;
        l0 = load_cnt;
        send_frame(12, 1'b0, 8'h01);
        wait_start(s0 + 1);
        repeat (5) @(negedge clk);
        enc_reply(v, 1'b1, 1'b0);
        wait_done(d0 + 1);
        chk("t5_bytes_sent", 32'(load_cnt - l0), 32'(N_TX));
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // All-0xA5 command; checksum build appends a 0x00 byte.
        v = pat(8'hA5, 0);
        push_expected(v);
        s0 = start_cnt;
        l0 = load_cnt;
        d0 = done_cnt;
        send_frame(18, 1'b0, 8'hC0);
        wait_start(s0 + 1);
        repeat (2) @(negedge clk);
        enc_reply(v, 1'b1, 1'b0);
        wait_done(d0 + 1);
        chk("t6_bytes_sent", 32'(load_cnt - l0), 32'(N_TX));
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef FRAME_CHECKSUM_EN
        chk("t6_last_byte", {24'h0, last_tx}, 32'h0000_0000);
`else
        chk("t6_last_byte", {24'h0, last_tx}, 32'h0000_00A5);
`endif
        repeat (3) @(negedge clk);
        chk("t6_idle_ready", {31'h0, frame_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
